// File: rtl/f6_pkg.sv
// Shared definitions for the F6 fully-connected layer sequencer.
// Contents: FSM state enum, default layer geometry, and the per-neuron beat
// count (weights plus optional bias slot).
// Macro: F6_BIAS_EN -- when defined, each neuron carries one extra bias beat.
package f6_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, COMP, DONE} f6_state_t;

  localparam int F6_NW  = 120;
  localparam int F6_NUM = 84;

`ifdef F6_BIAS_EN
  localparam int F6_BIAS = 1;
`else
  localparam int F6_BIAS = 0;
`endif

  localparam int F6_BEATS = F6_NW + F6_BIAS;

  // Beats per neuron for an arbitrary weight count.
  function automatic int f6_beats(input int nw);
    return nw + F6_BIAS;
  endfunction

endpackage

// File: rtl/f6_beat_cnt.sv
// Index counter with synchronous clear, increment and wrap.
// Ports:
//   i_sclk, i_rstn : clock, synchronous active-low reset
//   clr            : force count back to INIT
//   inc            : advance; wraps to INIT when at LAST
//   cnt            : current count
//   tc             : terminal flag, cnt == LAST
module f6_beat_cnt #(
  parameter logic [7:0] INIT = 8'd0,
  parameter logic [7:0] LAST = 8'd0
) (
  input  logic       i_sclk,
  input  logic       i_rstn,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt,
  output logic       tc
);

  assign tc = (cnt == LAST);

  always_ff @(posedge i_sclk) begin
    if (!i_rstn || clr) begin
      cnt <= INIT;
    end else if (inc) begin
      cnt <= tc ? INIT : cnt + 8'd1;
    end
  end

endmodule

// File: rtl/f6_layer_sched.sv
// F6 layer sequencer: per neuron, stores the incoming weight stream into the
// weight buffer, then issues one MAC read beat per stored word.
// Macro: F6_BIAS_EN (via f6_pkg) adds a bias word at address NW per neuron.
// Ports:
//   i_sclk, i_rstn        : clock, synchronous active-low reset
//   i_start, i_abort      : run pulse / abandon-run level
//   s_w_valid/data/ready  : upstream weight stream
//   o_w_en/num/addr/weight: weight buffer write port (num is 1-based)
//   o_rd_addr, o_mac_*    : MAC read address and control strobes
//   o_busy, o_done        : status
//
// state | meaning
// IDLE  | waiting for i_start
// LOAD  | accepting weight beats for the current neuron
// COMP  | issuing one MAC beat per cycle, no stalls
// DONE  | final neuron finished; o_done is raised on the way back to IDLE
module f6_layer_sched
  import f6_pkg::*;
#(
  parameter int WD  = 8,
  parameter int NW  = F6_NW,
  parameter int NUM = F6_NUM
) (
  input  logic          i_sclk,
  input  logic          i_rstn,
  input  logic          i_start,
  input  logic          i_abort,
  input  logic          s_w_valid,
  input  logic [WD-1:0] s_w_data,
  output logic          s_w_ready,
  output logic          o_w_en,
  output logic [7:0]    o_w_num,
  output logic [7:0]    o_w_addr,
  output logic [WD-1:0] o_weight,
  output logic [7:0]    o_rd_addr,
  output logic          o_mac_en,
  output logic          o_mac_clr,
  output logic          o_mac_last,
  output logic          o_busy,
  output logic          o_done
);

  localparam int         BEATS     = f6_beats(NW);
  localparam logic [7:0] BEAT_LAST = 8'(BEATS - 1);
  localparam logic [7:0] NUM_LAST  = 8'(NUM);

  f6_state_t  state;
  logic       hs;
  logic       beat_inc;
  logic       num_inc;
  logic       beat_tc;
  logic       num_tc;
  logic [7:0] beat;

  assign s_w_ready = (state == LOAD) && !i_abort;
  assign hs        = s_w_valid && s_w_ready;

  // The beat index serves both phases: accepted beats in LOAD, read beats in COMP.
  assign beat_inc = hs || ((state == COMP) && !i_abort);
  assign num_inc  = (state == COMP) && beat_tc && !i_abort;

  f6_beat_cnt #(.INIT(8'd0), .LAST(BEAT_LAST)) u_beat_cnt (
    .i_sclk (i_sclk),
    .i_rstn (i_rstn),
    .clr    (i_abort),
    .inc    (beat_inc),
    .cnt    (beat),
    .tc     (beat_tc)
  );

  // Neuron index wraps from NUM back to 1 as the last neuron completes.
  f6_beat_cnt #(.INIT(8'd1), .LAST(NUM_LAST)) u_num_cnt (
    .i_sclk (i_sclk),
    .i_rstn (i_rstn),
    .clr    (i_abort),
    .inc    (num_inc),
    .cnt    (o_w_num),
    .tc     (num_tc)
  );

  always_ff @(posedge i_sclk) begin
    if (!i_rstn || i_abort) begin
      state      <= IDLE;
      o_w_en     <= 1'b0;
      o_w_addr   <= '0;
      o_weight   <= '0;
      o_rd_addr  <= '0;
      o_mac_en   <= 1'b0;
      o_mac_clr  <= 1'b0;
      o_mac_last <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_w_en     <= hs;
      o_mac_en   <= 1'b0;
      o_mac_clr  <= 1'b0;
      o_mac_last <= 1'b0;
      o_done     <= 1'b0;
      if (hs) begin
        o_w_addr <= beat;
        o_weight <= s_w_data;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state  <= LOAD;
            o_busy <= 1'b1;
          end
        end
        LOAD: begin
          if (hs && beat_tc) state <= COMP;
        end
        COMP: begin
          o_mac_en   <= 1'b1;
          o_rd_addr  <= beat;
          o_mac_clr  <= (beat == 8'd0);
          o_mac_last <= beat_tc;
          if (beat_tc) state <= num_tc ? DONE : LOAD;
        end
        DONE: begin
          state  <= IDLE;
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f6_layer_sched.sv
// Randomized bench for f6_layer_sched with a small NW=4, NUM=2 layer.
// Observed writes, MAC beats and done pulses are collected by a monitor and
// compared against the sequence expected from the layer geometry.
module tb_f6_layer_sched;

  localparam int WD  = 8;
  localparam int NW  = 4;
  localparam int NUM = 2;
`ifdef F6_BIAS_EN
  localparam int BEATS = NW + 1;
`else
  localparam int BEATS = NW;
`endif
  localparam int TOTAL = NUM * BEATS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic          s_w_valid = 1'b0;
  logic [WD-1:0] s_w_data = '0;
  logic          s_w_ready;
  logic          o_w_en;
  logic [7:0]    o_w_num;
  logic [7:0]    o_w_addr;
  logic [WD-1:0] o_weight;
  logic [7:0]    o_rd_addr;
  logic          o_mac_en;
  logic          o_mac_clr;
  logic          o_mac_last;
  logic          o_busy;
  logic          o_done;

  f6_layer_sched #(.WD(WD), .NW(NW), .NUM(NUM)) dut (
    .i_sclk     (clk),
    .i_rstn     (rstn),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .s_w_valid  (s_w_valid),
    .s_w_data   (s_w_data),
    .s_w_ready  (s_w_ready),
    .o_w_en     (o_w_en),
    .o_w_num    (o_w_num),
    .o_w_addr   (o_w_addr),
    .o_weight   (o_weight),
    .o_rd_addr  (o_rd_addr),
    .o_mac_en   (o_mac_en),
    .o_mac_clr  (o_mac_clr),
    .o_mac_last (o_mac_last),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  always #5 clk = ~clk;

  typedef struct {int num; int addr; int data; int cyc;} wr_t;
  typedef struct {int addr; int clr; int last; int cyc;} mac_t;

  wr_t  wq[$];
  mac_t mq[$];
  int   dq[$];
  int   list[$];
  int   cyc_g = 0;
  int   nchk = 0;
  int   npass = 0;

  always @(posedge clk) cyc_g <= cyc_g + 1;

  always @(negedge clk) begin
    if (o_w_en) wq.push_back('{int'(o_w_num), int'(o_w_addr), int'(o_weight), cyc_g});
    if (o_mac_en) mq.push_back('{int'(o_rd_addr), int'(o_mac_clr), int'(o_mac_last), cyc_g});
    if (o_done) dq.push_back(cyc_g);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    nchk++;
    if (obs == exp) npass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic clear_mon();
    wq.delete();
    mq.delete();
    dq.delete();
  endtask

  // Outputs expected in reset, after abort, and in IDLE.
  task automatic check_idle(input string tag);
    chk({tag, ".w_en"},     o_w_en, 0);
    chk({tag, ".w_num"},    o_w_num, 1);
    chk({tag, ".w_addr"},   o_w_addr, 0);
    chk({tag, ".weight"},   o_weight, 0);
    chk({tag, ".rd_addr"},  o_rd_addr, 0);
    chk({tag, ".mac_en"},   o_mac_en, 0);
    chk({tag, ".mac_clr"},  o_mac_clr, 0);
    chk({tag, ".mac_last"}, o_mac_last, 0);
    chk({tag, ".busy"},     o_busy, 0);
    chk({tag, ".done"},     o_done, 0);
    chk({tag, ".ready"},    s_w_ready, 0);
  endtask

  // Starts a run and feeds the weight list. Stops when:
  //   mode 0: o_done seen, mode 1: two beats accepted, mode 2: mid-COMP of neuron 2.
  // Returns at negedge+1 with inputs idle except as noted by the caller.
  task automatic drive(input int gap, input bit poke, input int mode, output bit ok);
    int idx;
    int cyc;
    bit hs;
    idx = 0;
    cyc = 0;
    ok  = 1'b0;
    list.delete();
    for (int k = 0; k < TOTAL; k++) list.push_back(int'($urandom_range(255)));
    clear_mon();
    i_start = 1'b1;
    @(negedge clk); #1;
    i_start = 1'b0;
    while (cyc < 4000) begin
      if (mode == 0 && dq.size() > 0) begin ok = 1'b1; break; end
      if (mode == 1 && idx == 2) begin ok = 1'b1; break; end
      if (mode == 2 && o_mac_en && o_w_num == 8'd2 && o_rd_addr == 8'd1) begin ok = 1'b1; break; end
      s_w_valid = (idx < TOTAL) && (int'($urandom_range(99)) >= gap);
      s_w_data  = (idx < TOTAL) ? WD'(list[idx]) : '0;
      i_start   = poke && o_mac_en && !i_start && ($urandom_range(1) == 0);
      #1 hs = s_w_valid && s_w_ready;
      @(negedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    s_w_valid = 1'b0;
    i_start   = 1'b0;
  endtask

  // Compares a completed run against the expected neuron-by-neuron sequence.
  task automatic check_run(input string tag);
    int n;
    int a;
    chk({tag, ".n_wr"},   wq.size(), TOTAL);
    chk({tag, ".n_mac"},  mq.size(), TOTAL);
    chk({tag, ".n_done"}, dq.size(), 1);
    for (int k = 0; k < TOTAL; k++) begin
      n = k / BEATS + 1;
      a = k % BEATS;
      if (k < wq.size()) begin
        chk({tag, ".wr_num"},  wq[k].num, n);
        chk({tag, ".wr_addr"}, wq[k].addr, a);
        chk({tag, ".wr_data"}, wq[k].data, list[k]);
      end
      if (k < mq.size()) begin
        chk({tag, ".rd_addr"}, mq[k].addr, a);
        chk({tag, ".mac_clr"}, mq[k].clr, (a == 0) ? 1 : 0);
        chk({tag, ".mac_last"}, mq[k].last, (a == BEATS - 1) ? 1 : 0);
        if (a > 0) chk({tag, ".mac_gapless"}, mq[k].cyc, mq[k-1].cyc + 1);
        if (a == 0 && (k + BEATS - 1) < wq.size())
          chk({tag, ".mac_after_wr"}, int'(mq[k].cyc > wq[k + BEATS - 1].cyc), 1);
      end
    end
    if (dq.size() > 0 && mq.size() > 0) chk({tag, ".done_time"}, dq[0], mq[mq.size()-1].cyc + 1);
    repeat (4) @(negedge clk);
    chk({tag, ".done_once"}, dq.size(), 1);
    chk({tag, ".idle_busy"}, o_busy, 0);
  endtask

  initial begin
    bit ok;
    int gaps[3] = '{40, 60, 20};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_idle("reset");
    rstn = 1'b1;
    @(negedge clk); #1;

    drive(0, 1'b0, 0, ok);
    chk("run_full.bound", ok, 1);
    check_run("run_full");

    for (int r = 0; r < 3; r++) begin
      drive(gaps[r], r != 0, 0, ok);
      chk("run_gap.bound", ok, 1);
      check_run("run_gap");
    end

    drive(10, 1'b0, 1, ok);
    chk("abort.bound", ok, 1);
    i_abort   = 1'b1;
    s_w_valid = 1'b1;
    #1 chk("abort.ready_low", s_w_ready, 0);
    @(negedge clk); #1;
    i_abort   = 1'b0;
    s_w_valid = 1'b0;
    check_idle("abort");
    chk("abort.n_wr", wq.size(), 2);
    repeat (4) @(negedge clk);
    chk("abort.no_done", dq.size(), 0);
    #1;
    drive(30, 1'b0, 0, ok);
    chk("restart.bound", ok, 1);
    check_run("restart");

    drive(0, 1'b0, 2, ok);
    chk("rst_mid.bound", ok, 1);
    rstn = 1'b0;
    @(negedge clk); #1;
    check_idle("rst_mid");
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid.no_done", dq.size(), 0);
    #1;
    drive(25, 1'b1, 0, ok);
    chk("after_rst.bound", ok, 1);
    check_run("after_rst");

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
